// File: rtl/five_bit_demux_four_buf.sv
// Registered 1:4 demultiplexer for 5-bit words with per-channel holding buffers,
// select or round-robin routing, and an accepted-word counter.
module five_bit_demux_four_buf #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    input  logic             rr_mode,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] accept_count
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target;
    logic             accept;

    // A full target that drains this cycle can take a new word (no bubble).
    always_comb begin
        target   = rr_mode ? rr_ptr_q : select;
        in_ready = rst_n & (~valid_q[target] | out_ready[target]);
        accept   = in_valid & in_ready;
    end

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q & ~out_ready;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            data_d[target]  = in_data;
            valid_d[target] = 1'b1;
            cnt_d           = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (rr_mode) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out1         = data_q[0];
    assign out2         = data_q[1];
    assign out3         = data_q[2];
    assign out4         = data_q[3];
    assign out_valid    = valid_q;
    assign rr_ptr       = rr_ptr_q;
    assign accept_count = cnt_q;

endmodule

// File: tb/tb_five_bit_demux_four_buf.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a channel/queue-level reference model held in plain integers.
module tb_five_bit_demux_four_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] select;
    logic       rr_mode;
    logic [4:0] out1, out2, out3, out4;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;
    logic [7:0] accept_count;

    five_bit_demux_four_buf #(.WIDTH(5), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .select       (select),
        .rr_mode      (rr_mode),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .out4         (out4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rr_ptr       (rr_ptr),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    logic [4:0] outs [4];
    assign outs[0] = out1;
    assign outs[1] = out2;
    assign outs[2] = out3;
    assign outs[3] = out4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-channel word and full flag, pointer and counter as ints.
    int md [4];
    bit mv [4];
    int mrr;
    int mcnt;
    bit seeded = 1'b0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the DUT against the model, clocks once, then advances the model.
    task automatic cycle();
        int t;
        bit er;
        bit acc;
        #3;
        t  = rr_mode ? mrr : int'(select);
        er = rst_n && (!mv[t] || out_ready[t]);
        check_eq("in_ready", in_ready, er);
        if (seeded) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("out%0d", i + 1), outs[i], md[i]);
                check_eq($sformatf("out_valid[%0d]", i), out_valid[i], mv[i]);
            end
            check_eq("rr_ptr", rr_ptr, mrr);
            check_eq("accept_count", accept_count, mcnt);
        end
        acc = in_valid && er;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                md[i] = 0;
                mv[i] = 1'b0;
            end
            mrr    = 0;
            mcnt   = 0;
            seeded = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_ready[i]) mv[i] = 1'b0;
            end
            if (acc) begin
                md[t] = int'(in_data);
                mv[t] = 1'b1;
                mcnt  = (mcnt + 1) % 256;
                if (rr_mode) mrr = (mrr + 1) % 4;
            end
        end
    endtask

    task automatic drive(input bit v, input int d, input int sel, input bit rr, input int ordy);
        in_valid  = v;
        in_data   = 5'(d);
        select    = 2'(sel);
        rr_mode   = rr;
        out_ready = 4'(ordy);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        mrr   = 0;
        mcnt  = 0;
        for (int i = 0; i < 4; i++) begin
            md[i] = 0;
            mv[i] = 1'b0;
        end

        // Reset held with in_valid high
        drive(1, 5'h15, 0, 0, 0);
        drive(1, 5'h15, 0, 0, 0);
        check_eq("rst in_ready", in_ready, 0);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst out1", out1, 0);
        check_eq("rst out4", out4, 0);
        check_eq("rst count", accept_count, 0);
        check_eq("rst rr_ptr", rr_ptr, 0);
        rst_n = 1'b1;

        // Select routing
        drive(1, 5'h11, 2, 0, 0);
        drive(1, 5'h0A, 0, 0, 0);
        check_eq("sel out3", out3, 5'h11);
        check_eq("sel out1", out1, 5'h0A);
        check_eq("sel out_valid", out_valid, 4'b0101);
        check_eq("sel count", accept_count, 2);

        // Backpressure then pass-through on out2
        drive(1, 5'h1F, 1, 0, 0);
        drive(1, 5'h03, 1, 0, 0);
        check_eq("bp in_ready", in_ready, 0);
        check_eq("bp out2", out2, 5'h1F);
        drive(1, 5'h03, 1, 0, 4'b0010);
        check_eq("pt out2", out2, 5'h03);
        check_eq("pt out_valid[1]", out_valid[1], 1);

        // Round-robin
        drive(0, 0, 0, 1, 4'hF);
        for (int i = 1; i <= 6; i++) begin
            check_eq("rr seq", rr_ptr, (i - 1) % 4);
            drive(1, i, 0, 1, 4'hF);
        end
        check_eq("rr end", rr_ptr, 2);
        check_eq("rr out1", out1, 5);
        check_eq("rr out2", out2, 6);
        check_eq("rr out4", out4, 4);

        // Round-robin stall at rr_ptr=1 with out2 full
        drive(0, 0, 0, 1, 4'hF);
        for (int i = 0; i < 3; i++) drive(1, 5'h08 + i, 0, 1, 4'hF);
        drive(1, 5'h15, 1, 0, 0);
        check_eq("stall pre rr", rr_ptr, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'h09, 0, 1, 0);
            check_eq("stall rr", rr_ptr, 1);
            check_eq("stall in_ready", in_ready, 0);
        end
        drive(1, 5'h09, 0, 1, 4'b0010);
        check_eq("unstall out2", out2, 5'h09);
        check_eq("unstall rr", rr_ptr, 2);

        // Counter wrap
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) drive(1, int'($urandom_range(0, 31)), 0, 1, 4'hF);
        check_eq("wrap count", accept_count, 0);

        // Mid-operation reset with all channels full
        drive(0, 0, 0, 1, 4'hF);
        for (int i = 0; i < 4; i++) drive(1, 5'h10 + i, 0, 1, 0);
        check_eq("full out_valid", out_valid, 4'hF);
        rst_n = 1'b0;
        drive(1, 5'h1E, 0, 1, 0);
        rst_n = 1'b1;
        check_eq("midrst out_valid", out_valid, 0);
        check_eq("midrst rr_ptr", rr_ptr, 0);
        check_eq("midrst out3", out3, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
